arm_mem_port_arbiter: RTL and testbench

//  Shares the single unified instruction/data memory of the multicycle ARM core

---
 rtl/arm_mem_port_arbiter_pkg.sv | 24 ++
 rtl/arm_mem_port_arbiter_if.sv | 54 +++++
 rtl/arm_mem_port_arbiter_prio_select.sv | 48 ++++
 rtl/arm_mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_arm_mem_port_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/arm_mem_port_arbiter_pkg.sv
// Purpose: shared types and constants for the unified-memory port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package arm_mem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } arb_port_t;

  // Word accesses only: any set bit under this mask is a misaligned address.
  localparam logic [1:0] ARB_ALIGN_MASK = 2'b11;

  function automatic logic arb_is_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb & ARB_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/arm_mem_port_arbiter_if.sv
// Purpose: request/response bundle for the fetch port, load/store port and memory.
// Latency: n/a (wires only).
// Backpressure: req held by requester until its one-cycle ack.
// Modports: slave = arbiter view (takes requests, drives memory);
//           master = requester/memory view (drives requests and read data).
interface arm_mem_port_arbiter_if #(
  parameter int BusWidth = 32
);

  // Instruction fetch port
  logic                i_I_Req;
  logic [BusWidth-1:0] i_I_Address;
  logic [BusWidth-1:0] o_I_ReadData;
  logic                o_I_Ack;
  logic                o_I_Err;

  // Load/store port
  logic                i_D_Req;
  logic                i_D_WriteEnable;
  logic [BusWidth-1:0] i_D_Address;
  logic [BusWidth-1:0] i_D_WriteData;
  logic [BusWidth-1:0] o_D_ReadData;
  logic                o_D_Ack;
  logic                o_D_Err;

  // Memory side
  logic [BusWidth-1:0] o_MemAddress;
  logic [BusWidth-1:0] o_MemWriteData;
  logic                o_MemWriteEnable;
  logic [BusWidth-1:0] i_MemReadData;

  logic                o_Busy;

  modport slave (
    input  i_I_Req, i_I_Address,
    output o_I_ReadData, o_I_Ack, o_I_Err,
    input  i_D_Req, i_D_WriteEnable, i_D_Address, i_D_WriteData,
    output o_D_ReadData, o_D_Ack, o_D_Err,
    output o_MemAddress, o_MemWriteData, o_MemWriteEnable,
    input  i_MemReadData,
    output o_Busy
  );

  modport master (
    output i_I_Req, i_I_Address,
    input  o_I_ReadData, o_I_Ack, o_I_Err,
    output i_D_Req, i_D_WriteEnable, i_D_Address, i_D_WriteData,
    input  o_D_ReadData, o_D_Ack, o_D_Err,
    input  o_MemAddress, o_MemWriteData, o_MemWriteEnable,
    output i_MemReadData,
    input  o_Busy
  );

endinterface

// File: rtl/arm_mem_port_arbiter_prio_select.sv
// Purpose: fixed-priority (D over I) winner select with a fetch starvation counter.
// Latency: grant is combinational; counter updates on the sampling edge.
// Backpressure: none; losing requester simply keeps its req high.
// Ports: i_CLK, i_RESET, req_i, req_d, sample_en -> o_grant_vld, o_grant_port.
module arm_mem_prio_select
  import arm_mem_pkg::*;
#(
  parameter int StarveLimit = 4
) (
  input  logic      i_CLK,
  input  logic      i_RESET,
  input  logic      req_i,
  input  logic      req_d,
  input  logic      sample_en,
  output logic      o_grant_vld,
  output arb_port_t o_grant_port
);

  localparam int                CntW   = $clog2(StarveLimit + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(StarveLimit);

  logic [CntW-1:0] r_starve_cnt;
  logic            w_starved;

  assign w_starved = (r_starve_cnt == CntMax);

  always_comb begin
    o_grant_vld  = req_i | req_d;
    o_grant_port = PORT_D;
    // Fetch wins when alone, or when D has beaten a waiting fetch StarveLimit times.
    if (req_i && (!req_d || w_starved)) begin
      o_grant_port = PORT_I;
    end
  end

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      r_starve_cnt <= '0;
    end else if (sample_en && o_grant_vld) begin
      if (o_grant_port == PORT_I) begin
        r_starve_cnt <= '0;
      end else if (req_i && !w_starved) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/arm_mem_port_arbiter.sv
// Purpose: shares one unified memory between fetch (I) and load/store (D) requesters.
// Latency: req sampled in IDLE cycle N -> ack in cycle N+2; one access per 3 cycles.
// Backpressure: requests sampled only in IDLE; a loser holds req until served.
// Ports: i_CLK, i_RESET (async, active-high), bus (slave modport: I/D request
//        ports, memory address/wdata/we/rdata, busy).
module arm_mem_port_arbiter
  import arm_mem_pkg::*;
#(
  parameter int BusWidth    = 32,
  parameter int StarveLimit = 4
) (
  input  logic                 i_CLK,
  input  logic                 i_RESET,
  arm_mem_port_arbiter_if.slave bus
);

  arb_state_t          r_state;
  arb_state_t          w_next_state;
  arb_port_t           r_winner;
  logic [BusWidth-1:0] r_addr;
  logic [BusWidth-1:0] r_wdata;
  logic                r_we;
  logic                r_misalign;
  logic [BusWidth-1:0] r_i_rdata;
  logic [BusWidth-1:0] r_d_rdata;

  logic                w_sample_en;
  logic                w_grant_vld;
  arb_port_t           w_grant_port;
  logic [BusWidth-1:0] w_sel_addr;

  assign w_sample_en = (r_state == ARB_IDLE);
  assign w_sel_addr  = (w_grant_port == PORT_D) ? bus.i_D_Address : bus.i_I_Address;

  arm_mem_prio_select #(
    .StarveLimit (StarveLimit)
  ) u_prio_select (
    .i_CLK        (i_CLK),
    .i_RESET      (i_RESET),
    .req_i        (bus.i_I_Req),
    .req_d        (bus.i_D_Req),
    .sample_en    (w_sample_en),
    .o_grant_vld  (w_grant_vld),
    .o_grant_port (w_grant_port)
  );

  // State register
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and outputs. Acks/errs/we decode straight from the state so an
  // async reset kills them in the same cycle.
  always_comb begin
    w_next_state         = r_state;
    bus.o_MemWriteEnable = 1'b0;
    bus.o_I_Ack          = 1'b0;
    bus.o_I_Err          = 1'b0;
    bus.o_D_Ack          = 1'b0;
    bus.o_D_Err          = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_grant_vld) begin
          w_next_state = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        bus.o_MemWriteEnable = r_we & ~r_misalign;
        w_next_state         = ARB_RESP;
      end
      ARB_RESP: begin
        bus.o_I_Ack  = (r_winner == PORT_I);
        bus.o_I_Err  = (r_winner == PORT_I) & r_misalign;
        bus.o_D_Ack  = (r_winner == PORT_D);
        bus.o_D_Err  = (r_winner == PORT_D) & r_misalign;
        w_next_state = ARB_IDLE;
      end
      default: begin
        w_next_state = ARB_IDLE;
      end
    endcase
  end

  // Request latch, taken only on the IDLE sampling edge.
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      r_winner   <= PORT_I;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_misalign <= 1'b0;
    end else if (w_sample_en && w_grant_vld) begin
      r_winner   <= w_grant_port;
      r_addr     <= w_sel_addr;
      r_misalign <= arb_is_misaligned(w_sel_addr[1:0]);
      if (w_grant_port == PORT_D) begin
        r_wdata <= bus.i_D_WriteData;
        r_we    <= bus.i_D_WriteEnable;
      end else begin
        // Fetch never writes; r_wdata keeps its last value on the memory bus.
        r_we    <= 1'b0;
      end
    end
  end

  // Read capture: only the winner's register moves, and only during ACCESS.
  // A store also captures (the pre-write memory word).
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else if (r_state == ARB_ACCESS) begin
      if (r_winner == PORT_I) begin
        r_i_rdata <= r_misalign ? '0 : bus.i_MemReadData;
      end else begin
        r_d_rdata <= r_misalign ? '0 : bus.i_MemReadData;
      end
    end
  end

  assign bus.o_MemAddress   = r_addr;
  assign bus.o_MemWriteData = r_wdata;
  assign bus.o_I_ReadData   = r_i_rdata;
  assign bus.o_D_ReadData   = r_d_rdata;
  assign bus.o_Busy         = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_arm_mem_port_arbiter.sv
// Purpose: directed, table-driven check of the memory port arbiter with a small
//          word memory model; hand sequences cover starvation, reset and release.
// Latency/backpressure: inputs driven and outputs sampled 1ns after rising edges.
module tb_arm_mem_port_arbiter;

  logic clk;
  logic rst;
  logic mem_load;
  int   n_chk;
  int   n_fail;

  arm_mem_port_arbiter_if #(.BusWidth(32)) bus ();

  arm_mem_port_arbiter #(
    .BusWidth    (32),
    .StarveLimit (4)
  ) dut (
    .i_CLK   (clk),
    .i_RESET (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: combinational read, write on rising edge.
  logic [31:0] mem [0:255];
  assign bus.i_MemReadData = mem[bus.o_MemAddress[9:2]];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'h0;
      mem[1] <= 32'hE280_2005;
      mem[2] <= 32'h1122_3344;
    end else if (bus.o_MemWriteEnable) begin
      mem[bus.o_MemAddress[9:2]] <= bus.o_MemWriteData;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_reqs();
    bus.i_I_Req = 1'b0;
    bus.i_D_Req = 1'b0;
  endtask

  typedef struct {
    logic        ireq;
    logic        dreq;
    logic        dwe;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] wd;
    logic        exp_d;     // 1: D port expected to win
    logic [31:0] exp_addr;
    logic        exp_we;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [9];

  initial begin : main
    int   grants;
    logic order [10];
    logic exp_order [10];
    int   n;

    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    mem_load = 1'b1;
    drop_reqs();
    bus.i_I_Address     = '0;
    bus.i_D_Address     = '0;
    bus.i_D_WriteData   = '0;
    bus.i_D_WriteEnable = 1'b0;

    //         ireq  dreq  dwe   ia        da          wd            exp_d exp_addr    we    err   rd
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h4,   32'h0,      32'h0,        1'b0, 32'h4,      1'b0, 1'b0, 32'hE280_2005};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h100,    32'hDEAD_BEEF, 1'b1, 32'h100,   1'b1, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h100,    32'h0,        1'b1, 32'h100,    1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h102,    32'h1234_5678, 1'b1, 32'h102,   1'b0, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h100,    32'h0,        1'b1, 32'h100,    1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h6,   32'h0,      32'h0,        1'b0, 32'h6,      1'b0, 1'b1, 32'h0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h8,   32'h100,    32'h0,        1'b1, 32'h100,    1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 32'h8,   32'h0,      32'h0,        1'b0, 32'h8,      1'b0, 1'b0, 32'h1122_3344};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h4,      32'h0,        1'b1, 32'h4,      1'b0, 1'b0, 32'hE280_2005};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",   {31'b0, bus.o_Busy},           32'h0);
    chk("rst_we",     {31'b0, bus.o_MemWriteEnable}, 32'h0);
    chk("rst_iack",   {31'b0, bus.o_I_Ack},          32'h0);
    chk("rst_dack",   {31'b0, bus.o_D_Ack},          32'h0);
    chk("rst_ird",    bus.o_I_ReadData,              32'h0);
    chk("rst_drd",    bus.o_D_ReadData,              32'h0);
    chk("rst_maddr",  bus.o_MemAddress,              32'h0);
    rst      = 1'b0;
    mem_load = 1'b0;
    step();

    // Single transactions from the table
    for (int v = 0; v < 9; v++) begin
      bus.i_I_Req         = vecs[v].ireq;
      bus.i_D_Req         = vecs[v].dreq;
      bus.i_D_WriteEnable = vecs[v].dwe;
      bus.i_I_Address     = vecs[v].ia;
      bus.i_D_Address     = vecs[v].da;
      bus.i_D_WriteData   = vecs[v].wd;
      step();  // ACCESS
      chk($sformatf("v%0d_acc_busy", v), {31'b0, bus.o_Busy}, 32'h1);
      chk($sformatf("v%0d_acc_addr", v), bus.o_MemAddress, vecs[v].exp_addr);
      chk($sformatf("v%0d_acc_we", v), {31'b0, bus.o_MemWriteEnable}, {31'b0, vecs[v].exp_we});
      chk($sformatf("v%0d_acc_noack", v), {30'b0, bus.o_I_Ack, bus.o_D_Ack}, 32'h0);
      step();  // RESP
      chk($sformatf("v%0d_resp_we", v), {31'b0, bus.o_MemWriteEnable}, 32'h0);
      chk($sformatf("v%0d_acks", v), {30'b0, bus.o_I_Ack, bus.o_D_Ack},
          vecs[v].exp_d ? 32'h1 : 32'h2);
      chk($sformatf("v%0d_errs", v), {30'b0, bus.o_I_Err, bus.o_D_Err},
          {30'b0, ~vecs[v].exp_d & vecs[v].exp_err, vecs[v].exp_d & vecs[v].exp_err});
      chk($sformatf("v%0d_rdata", v), vecs[v].exp_d ? bus.o_D_ReadData : bus.o_I_ReadData,
          vecs[v].exp_rd);
      drop_reqs();
      step();  // IDLE
      chk($sformatf("v%0d_idle_busy", v), {31'b0, bus.o_Busy}, 32'h0);
    end
    chk("mem_0x100_after_misaligned_store", mem[8'h40], 32'hDEAD_BEEF);

    // Both requesters held: starvation limit forces every fifth grant to I.
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    grants = 0;
    bus.i_I_Req         = 1'b1;
    bus.i_I_Address     = 32'h4;
    bus.i_D_Req         = 1'b1;
    bus.i_D_Address     = 32'h100;
    bus.i_D_WriteEnable = 1'b0;
    for (int c = 0; c < 40 && grants < 10; c++) begin
      step();
      if (bus.o_I_Ack || bus.o_D_Ack) begin
        order[grants] = bus.o_D_Ack;
        grants++;
      end
    end
    drop_reqs();
    chk("starve_grant_count", grants, 32'd10);
    for (int g = 0; g < 10; g++) begin
      if (g < grants) chk($sformatf("starve_grant%0d_is_d", g), {31'b0, order[g]}, {31'b0, exp_order[g]});
    end
    step();
    chk("starve_idle_busy", {31'b0, bus.o_Busy}, 32'h0);

    // Reset in the middle of a store access
    bus.i_D_Req         = 1'b1;
    bus.i_D_WriteEnable = 1'b1;
    bus.i_D_Address     = 32'h200;
    bus.i_D_WriteData   = 32'hCAFE_F00D;
    step();  // ACCESS
    chk("rst_mid_we_before", {31'b0, bus.o_MemWriteEnable}, 32'h1);
    #2;
    rst = 1'b1;
    drop_reqs();
    #1;
    chk("rst_mid_we_drop", {31'b0, bus.o_MemWriteEnable}, 32'h0);
    chk("rst_mid_busy",    {31'b0, bus.o_Busy},           32'h0);
    step();
    rst = 1'b0;
    step();
    chk("rst_mid_noack", {31'b0, bus.o_D_Ack}, 32'h0);
    chk("rst_mid_nowrite", mem[8'h80], 32'h0);
    bus.i_I_Req     = 1'b1;
    bus.i_I_Address = 32'h4;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      n++;
      if (bus.o_I_Ack) break;
    end
    chk("post_rst_ack_edges", n, 32'd2);
    chk("post_rst_ird", bus.o_I_ReadData, 32'hE280_2005);
    drop_reqs();
    step();

    // Both request, I gives up when D is acked: arbiter goes quiet.
    bus.i_I_Req         = 1'b1;
    bus.i_I_Address     = 32'h8;
    bus.i_D_Req         = 1'b1;
    bus.i_D_Address     = 32'h4;
    bus.i_D_WriteEnable = 1'b0;
    step();
    step();
    chk("rel_acks", {30'b0, bus.o_I_Ack, bus.o_D_Ack}, 32'h1);
    chk("rel_drd",  bus.o_D_ReadData, 32'hE280_2005);
    drop_reqs();
    step();
    chk("rel_idle_busy", {31'b0, bus.o_Busy}, 32'h0);
    step();
    chk("rel_idle_busy2", {31'b0, bus.o_Busy}, 32'h0);
    chk("rel_no_iack", {31'b0, bus.o_I_Ack}, 32'h0);
    chk("rel_ird_held", bus.o_I_ReadData, 32'hE280_2005);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
